stepper_ctrl: RTL and testbench
===============================

Name: stepper_ctrl

Overview:
Parametrised multi-channel stepper motor pulse generator. It replaces the fixed motor-on, direction and free-running step-divider wiring at the top level. The processor issues per-channel MOVE/STOP commands over a valid/ready interface. Each channel then produces a step pulse train with a programmable half-period, an exact or continuous step count, a direction setup delay, and a one-cycle completion pulse.

Parameters:
NUM_CH, 2, number of independent motor channels (1..8)
CNT_W, 18, width of half-period counter in clock cycles
STEP_W, 16, width of step count
SETUP_CYC, 4, cycles dir_out is stable before first step rising edge (>=1)
CH_W (localparam), max(1, clog2(NUM_CH)), channel index width

Ports:
clock  in  1  single system clock; all state on rising edge
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_ch  in  CH_W  target channel
cmd_op  in  2  00 NOP, 01 MOVE, 10 STOP, 11 reserved (treated as NOP)
cmd_dir  in  1  direction for MOVE
cmd_steps  in  STEP_W  step count for MOVE; 0 = continuous
cmd_half_period  in  CNT_W  high/low phase length in cycles; 0 treated as 1
step_out  out  NUM_CH  per-channel step pulse
dir_out  out  NUM_CH  per-channel direction
motor_on  out  NUM_CH  per-channel driver enable (= busy)
busy  out  NUM_CH  channel executing MOVE
done  out  NUM_CH  one-cycle pulse on MOVE completion or STOP abort

Behaviour:
- Reset (reset==0 at an edge):
  - All outputs 0; every channel FSM goes to IDLE; counters cleared.
  - A move in progress is abandoned with no done pulse.
  - Reset has priority over all commands.
- Per-channel FSM states: IDLE, SETUP, HIGH, LOW.
- cmd_ready is combinational:
  - MOVE: 1 iff cmd_ch < NUM_CH and busy[cmd_ch]==0.
  - STOP, NOP, reserved, or cmd_ch >= NUM_CH: always 1. Out-of-range channel commands are accepted and ignored.
- MOVE accepted at edge k:
  - At edge k: dir_out=cmd_dir, busy=motor_on=1, state=SETUP.
  - Steps remaining := cmd_steps; H := max(cmd_half_period, 1). Both are latched and unaffected by later inputs.
  - step_out rises at edge k+SETUP_CYC (HIGH) and falls at k+SETUP_CYC+H (LOW).
  - The next rise is at k+SETUP_CYC+2H, and so on; period is exactly 2H.
  - Each completed LOW phase decrements the remaining count when cmd_steps != 0.
  - When the final LOW phase ends, at edge k+SETUP_CYC+2H*N: state=IDLE, busy=0, done=1 for exactly one cycle.
  - Exactly N rising edges occur; step_out is low at completion.
  - cmd_steps==0: HIGH/LOW alternate indefinitely until STOP.
- STOP accepted at edge k on a busy channel:
  - At edge k: step_out=0, busy=motor_on=0, done=1 (one cycle), state=IDLE.
  - dir_out holds its value.
  - STOP on an idle channel: no effect, no done pulse.
- A new MOVE on a channel is accepted in the cycle after its done pulse at the earliest, because busy is low during the done cycle. If the new MOVE arrives in the done cycle itself, done is still issued and the new move starts at that edge.
- Channels run fully independently. Commands to different channels on consecutive cycles are all accepted. At most one command per cycle, by interface construction.
- dir_out changes only on MOVE acceptance, never mid-move.
- Counters do not wrap:
  - The phase counter counts to H-1 and reloads.
  - The step count saturates at 0 (its underflow path is unreachable).

Test Plan:
1. Reset low 3 cycles mid-move (ch0, steps=5) -> all outputs 0, no done pulse. After release, cmd_ready=1 and MOVE is accepted normally.
2. MOVE ch0, dir=1, steps=3, half_period=4, accepted at edge 10:
   - step_out[0] rises at edges 14, 22, 30 and falls at 18, 26, 34.
   - done[0]=1 only at edge 38; busy[0] is 1 from edge 10 to 37.
3. While ch0 is busy, MOVE to ch0 -> cmd_ready=0 and the command is held. Same-cycle MOVE to ch1 -> cmd_ready=1. Both channels produce independent, correct trains.
4. MOVE ch1, steps=0, half_period=0 -> step_out[1] toggles every cycle after 4 setup cycles. STOP ch1 at edge k -> step_out[1]=0 and busy[1]=0 at k, with done[1]=1 for one cycle.
5. STOP to idle ch0, and MOVE to cmd_ch=NUM_CH -> cmd_ready=1, no output change, no done pulse.
6. MOVE ch0, steps=1, half_period=2^CNT_W-1 -> a single pulse of full-width high time, no counter wrap, and done exactly 2H+SETUP_CYC cycles after accept.

Source files
------------

// File: rtl/stepper_ctrl.sv
// Multi-channel stepper pulse generator: per-channel MOVE/STOP commands over valid/ready,
// producing step trains with programmable half-period, step count and direction setup delay.
module stepper_ctrl #(
   parameter  int NUM_CH    = 2,
   parameter  int CNT_W     = 18,
   parameter  int STEP_W    = 16,
   parameter  int SETUP_CYC = 4,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [CH_W-1:0]   cmd_ch,
   input  logic [1:0]        cmd_op,
   input  logic              cmd_dir,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic [CNT_W-1:0]  cmd_half_period,
   output logic [NUM_CH-1:0] step_out,
   output logic [NUM_CH-1:0] dir_out,
   output logic [NUM_CH-1:0] motor_on,
   output logic [NUM_CH-1:0] busy,
   output logic [NUM_CH-1:0] done
);

   localparam int SW = $clog2(SETUP_CYC + 1);
   localparam logic [1:0] OP_MOVE = 2'b01;
   localparam logic [1:0] OP_STOP = 2'b10;

   typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

   logic accept;

   // Only a MOVE to an existing busy channel is back-pressured.
   always_comb begin
      cmd_ready = 1'b1;
      if (cmd_op == OP_MOVE) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cmd_ch == CH_W'(i)) cmd_ready = !busy[i];
         end
      end
   end

   assign accept = cmd_valid && cmd_ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_t            state, state_n;
      logic [CNT_W-1:0]  cnt, cnt_n, half, half_n;
      logic [SW-1:0]     scnt, scnt_n;
      logic [STEP_W-1:0] rem, rem_n;
      logic              cont, cont_n, dir, dir_n, done_r, done_n;
      logic              move_hit, stop_hit;

      assign move_hit = accept && (cmd_op == OP_MOVE) && (cmd_ch == CH_W'(g));
      assign stop_hit = accept && (cmd_op == OP_STOP) && (cmd_ch == CH_W'(g));

      always_ff @(posedge clock) begin
         if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            half   <= '0;
            scnt   <= '0;
            rem    <= '0;
            cont   <= 1'b0;
            dir    <= 1'b0;
            done_r <= 1'b0;
         end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            half   <= half_n;
            scnt   <= scnt_n;
            rem    <= rem_n;
            cont   <= cont_n;
            dir    <= dir_n;
            done_r <= done_n;
         end
      end

      always_comb begin
         state_n = state;
         cnt_n   = cnt;
         half_n  = half;
         scnt_n  = scnt;
         rem_n   = rem;
         cont_n  = cont;
         dir_n   = dir;
         done_n  = 1'b0;
         if (move_hit) begin
            state_n = SETUP;
            cnt_n   = '0;
            scnt_n  = '0;
            rem_n   = cmd_steps;
            cont_n  = (cmd_steps == '0);
            half_n  = (cmd_half_period == '0) ? CNT_W'(1) : cmd_half_period;
            dir_n   = cmd_dir;
         end else if (stop_hit && state != IDLE) begin
            state_n = IDLE;
            done_n  = 1'b1;
         end else begin
            case (state)
               SETUP: begin
                  if (scnt == SW'(SETUP_CYC - 1)) begin
                     state_n = HIGH;
                     cnt_n   = '0;
                  end else begin
                     scnt_n = scnt + SW'(1);
                  end
               end
               HIGH: begin
                  if (cnt == half - CNT_W'(1)) begin
                     state_n = LOW;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt + CNT_W'(1);
                  end
               end
               LOW: begin
                  if (cnt == half - CNT_W'(1)) begin
                     cnt_n = '0;
                     // rem==0 on a counted move cannot occur; treating it as final keeps the count saturated.
                     if (!cont && rem <= STEP_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                     end else begin
                        state_n = HIGH;
                        if (!cont) rem_n = rem - STEP_W'(1);
                     end
                  end else begin
                     cnt_n = cnt + CNT_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end

      assign step_out[g] = (state == HIGH);
      assign busy[g]     = (state != IDLE);
      assign motor_on[g] = (state != IDLE);
      assign done[g]     = done_r;
      assign dir_out[g]  = dir;
   end

endmodule

// File: tb/tb_stepper_ctrl.sv
// Randomized and directed checks of stepper_ctrl against a timing-arithmetic reference model.
module tb_stepper_ctrl;
   localparam int NUM_CH = 3;
   localparam int CNT_W = 10;
   localparam int STEP_W = 16;
   localparam int SETUP_CYC = 4;
   localparam int CH_W = 2;
   localparam longint NEVER = 64'sh3fff_ffff_ffff_ffff;
   localparam logic [1:0] NOP = 2'b00, MOVE = 2'b01, STOP = 2'b10, RSVD = 2'b11;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic cmd_valid = 1'b0;
   logic [CH_W-1:0] cmd_ch = '0;
   logic [1:0] cmd_op = '0;
   logic cmd_dir = 1'b0;
   logic [STEP_W-1:0] cmd_steps = '0;
   logic [CNT_W-1:0] cmd_half_period = '0;
   logic cmd_ready;
   logic [NUM_CH-1:0] step_out, dir_out, motor_on, busy, done;

   int compared = 0;
   int mismatched = 0;
   longint now = 0;

   // Model: each channel's move is described by accept edge, half-period and end edge.
   longint m_k[NUM_CH];
   longint m_h[NUM_CH];
   longint m_end[NUM_CH];
   bit m_valid[NUM_CH];
   logic [NUM_CH-1:0] m_dir = '0;

   stepper_ctrl #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .STEP_W(STEP_W), .SETUP_CYC(SETUP_CYC)) dut (
      .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ch(cmd_ch), .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
      .cmd_half_period(cmd_half_period), .step_out(step_out), .dir_out(dir_out),
      .motor_on(motor_on), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   function automatic bit f_busy(int ch, longint t);
      return m_valid[ch] && t >= m_k[ch] && t < m_end[ch];
   endfunction

   function automatic bit f_step(int ch, longint t);
      longint ph;
      if (!f_busy(ch, t) || t < m_k[ch] + SETUP_CYC) return 1'b0;
      ph = (t - m_k[ch] - SETUP_CYC) / m_h[ch];
      return (ph % 2) == 0;
   endfunction

   function automatic bit f_done(int ch, longint t);
      return m_valid[ch] && t == m_end[ch];
   endfunction

   function automatic bit exp_ready();
      if (cmd_op == MOVE && int'(cmd_ch) < NUM_CH) return !f_busy(int'(cmd_ch), now);
      return 1'b1;
   endfunction

   function automatic logic [5*NUM_CH-1:0] ev_all();
      logic [NUM_CH-1:0] s, b, d;
      for (int i = 0; i < NUM_CH; i++) begin
         s[i] = f_step(i, now);
         b[i] = f_busy(i, now);
         d[i] = f_done(i, now);
      end
      return {s, b, b, d, m_dir};
   endfunction

   task automatic set_cmd(bit v, int ch, logic [1:0] op, bit d, int steps, int hp);
      cmd_valid = v;
      cmd_ch = CH_W'(ch);
      cmd_op = op;
      cmd_dir = d;
      cmd_steps = STEP_W'(steps);
      cmd_half_period = CNT_W'(hp);
      #1;
   endtask

   task automatic clk_edge();
      bit acc;
      int ch;
      longint t;
      acc = cmd_valid && exp_ready();
      ch = int'(cmd_ch);
      t = now + 1;
      @(posedge clock);
      now = t;
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) m_valid[i] = 1'b0;
         m_dir = '0;
      end else if (acc && ch < NUM_CH) begin
         if (cmd_op == MOVE) begin
            m_valid[ch] = 1'b1;
            m_k[ch] = t;
            m_h[ch] = (cmd_half_period == '0) ? 64'sd1 : longint'(cmd_half_period);
            m_end[ch] = (cmd_steps == '0) ? NEVER : t + SETUP_CYC + 2 * m_h[ch] * longint'(cmd_steps);
            m_dir[ch] = cmd_dir;
         end else if (cmd_op == STOP && f_busy(ch, t - 1)) begin
            m_end[ch] = t;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      logic [5*NUM_CH-1:0] got;
      reset = 1'b0;
      set_cmd(0, 0, NOP, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         clk_edge();
         got = {step_out, busy, motor_on, done, dir_out};
         if (got !== '0) begin
            mismatched++;
            $display("FAIL reset_state t=%0d got %h want 0", now, got);
         end
         compared++;
      end
      for (int i = 0; i < 32; i++) begin
         reset = !(i >= 8 && i < 11);
         if (i == 0) set_cmd(1, 0, MOVE, 1, 5, 3);
         else if (i == 12) set_cmd(1, 0, MOVE, 0, 2, 1);
         else set_cmd(0, 0, NOP, 0, 0, 0);
         if (cmd_ready !== exp_ready()) begin
            mismatched++;
            $display("FAIL reset_ready t=%0d got %b want %b", now, cmd_ready, exp_ready());
         end
         compared++;
         clk_edge();
         got = {step_out, busy, motor_on, done, dir_out};
         if (got !== ev_all()) begin
            mismatched++;
            $display("FAIL reset_outputs t=%0d got %h want %h", now, got, ev_all());
         end
         compared++;
      end
   endtask

   task automatic test_single();
      logic [5*NUM_CH-1:0] got;
      longint k, done_t, rises[$], want[$];
      bit prev;
      k = -1;
      done_t = -1;
      prev = step_out[0];
      for (int i = 0; i < 36; i++) begin
         if (i == 0) set_cmd(1, 0, MOVE, 1, 3, 4);
         else set_cmd(0, 0, NOP, 0, 0, 0);
         if (i == 0) k = now + 1;
         if (cmd_ready !== exp_ready()) begin
            mismatched++;
            $display("FAIL single_ready t=%0d got %b want %b", now, cmd_ready, exp_ready());
         end
         compared++;
         clk_edge();
         got = {step_out, busy, motor_on, done, dir_out};
         if (got !== ev_all()) begin
            mismatched++;
            $display("FAIL single_outputs t=%0d got %h want %h", now, got, ev_all());
         end
         compared++;
         if (step_out[0] && !prev) rises.push_back(now - k);
         if (done[0] && done_t < 0) done_t = now - k;
         prev = step_out[0];
      end
      want = '{4, 12, 20};
      if (rises != want) begin
         mismatched++;
         $display("FAIL single_rise_edges got %p want %p", rises, want);
      end
      compared++;
      if (done_t !== 64'sd28) begin
         mismatched++;
         $display("FAIL single_done_edge got %0d want 28", done_t);
      end
      compared++;
   endtask

   task automatic test_back_to_back();
      logic [5*NUM_CH-1:0] got;
      bit second;
      second = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (i == 0) set_cmd(1, 0, MOVE, 1, 2, 3);
         else if (i == 5) set_cmd(1, 1, MOVE, 1, 3, 2);
         else if (i == 6) set_cmd(1, 2, MOVE, 0, 2, 1);
         else if (!second) set_cmd(1, 0, MOVE, 0, 1, 1);
         else set_cmd(0, 0, NOP, 0, 0, 0);
         if (cmd_ready !== exp_ready()) begin
            mismatched++;
            $display("FAIL b2b_ready t=%0d got %b want %b", now, cmd_ready, exp_ready());
         end
         compared++;
         if (i > 6 && !second && exp_ready()) second = 1'b1;
         clk_edge();
         got = {step_out, busy, motor_on, done, dir_out};
         if (got !== ev_all()) begin
            mismatched++;
            $display("FAIL b2b_outputs t=%0d got %h want %h", now, got, ev_all());
         end
         compared++;
      end
      if (!second) begin
         mismatched++;
         $display("FAIL b2b_held_move got not_accepted want accepted");
      end
      compared++;
   endtask

   task automatic test_continuous_stop();
      logic [5*NUM_CH-1:0] got;
      for (int i = 0; i < 24; i++) begin
         if (i == 0) set_cmd(1, 1, MOVE, 1, 0, 0);
         else if (i == 14 || i == 17) set_cmd(1, 1, STOP, 0, 0, 0);
         else set_cmd(0, 0, NOP, 0, 0, 0);
         if (cmd_ready !== exp_ready()) begin
            mismatched++;
            $display("FAIL cont_ready t=%0d got %b want %b", now, cmd_ready, exp_ready());
         end
         compared++;
         clk_edge();
         got = {step_out, busy, motor_on, done, dir_out};
         if (got !== ev_all()) begin
            mismatched++;
            $display("FAIL cont_outputs t=%0d got %h want %h", now, got, ev_all());
         end
         compared++;
      end
   endtask

   task automatic test_idle_ignore();
      logic [5*NUM_CH-1:0] got;
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: set_cmd(1, 0, STOP, 0, 0, 0);
            1: set_cmd(1, NUM_CH, MOVE, 1, 3, 2);
            2: set_cmd(1, 0, RSVD, 1, 3, 2);
            3: set_cmd(1, 1, NOP, 1, 3, 2);
            default: set_cmd(0, 0, NOP, 0, 0, 0);
         endcase
         if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ignore_ready t=%0d got %b want 1", now, cmd_ready);
         end
         compared++;
         clk_edge();
         got = {step_out, busy, motor_on, done, dir_out};
         if (got !== ev_all()) begin
            mismatched++;
            $display("FAIL ignore_outputs t=%0d got %h want %h", now, got, ev_all());
         end
         compared++;
      end
   endtask

   task automatic test_full_width();
      logic [5*NUM_CH-1:0] got;
      longint k, done_t, high_len;
      int hmax;
      hmax = (1 << CNT_W) - 1;
      k = now + 1;
      done_t = -1;
      high_len = 0;
      for (int i = 0; i < 2 * hmax + SETUP_CYC + 4; i++) begin
         if (i == 0) set_cmd(1, 0, MOVE, 0, 1, hmax);
         else set_cmd(0, 0, NOP, 0, 0, 0);
         clk_edge();
         got = {step_out, busy, motor_on, done, dir_out};
         if (got !== ev_all()) begin
            mismatched++;
            $display("FAIL full_outputs t=%0d got %h want %h", now, got, ev_all());
         end
         compared++;
         if (step_out[0]) high_len++;
         if (done[0] && done_t < 0) done_t = now - k;
      end
      if (high_len !== longint'(hmax) || done_t !== longint'(2 * hmax + SETUP_CYC)) begin
         mismatched++;
         $display("FAIL full_width got high=%0d done=%0d want high=%0d done=%0d",
                  high_len, done_t, hmax, 2 * hmax + SETUP_CYC);
      end
      compared++;
   endtask

   task automatic test_random();
      logic [5*NUM_CH-1:0] got;
      logic [1:0] op;
      for (int i = 0; i < 900; i++) begin
         reset = ($urandom_range(0, 299) != 0);
         op = 2'($urandom_range(0, 3));
         if (op == STOP && $urandom_range(0, 2) != 0) op = MOVE;
         set_cmd($urandom_range(0, 2) != 0, $urandom_range(0, 3), op, $urandom_range(0, 1),
                 $urandom_range(0, 4), $urandom_range(0, 3));
         if (cmd_ready !== exp_ready()) begin
            mismatched++;
            $display("FAIL rand_ready t=%0d got %b want %b", now, cmd_ready, exp_ready());
         end
         compared++;
         clk_edge();
         got = {step_out, busy, motor_on, done, dir_out};
         if (got !== ev_all()) begin
            mismatched++;
            $display("FAIL rand_outputs t=%0d got %h want %h", now, got, ev_all());
         end
         compared++;
      end
      reset = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < NUM_CH; i++) begin
         m_valid[i] = 1'b0;
         m_k[i] = 0;
         m_h[i] = 1;
         m_end[i] = 0;
      end
      @(negedge clock);
      test_reset();
      test_single();
      test_back_to_back();
      test_continuous_stop();
      test_idle_ignore();
      test_full_width();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached at t=%0d", now);
      $fatal(1);
   end

endmodule
